// File: rtl/block_spi_reg_decoder_pkg.sv
// Shared definitions for the SPI register decoder: header layout, FSM states,
// stats addresses and address helpers.
package block_spi_reg_decoder_pkg;

  localparam int         RW_BIT        = 7;
  localparam int         ADDR_W        = 7;
  localparam logic [6:0] ADDR_MAX      = 7'h7F;
  localparam logic [6:0] STAT_ERR_ADDR = 7'd126;
  localparam logic [6:0] STAT_FRM_ADDR = 7'd127;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_HEADER,
    S_WRITE,
    S_READ
  } state_t;

  // Address counter saturates at the top instead of wrapping to 0.
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    return (a == ADDR_MAX) ? a : a + 7'd1;
  endfunction

  function automatic logic in_range(input logic [6:0] a, input int n);
    return int'(a) < n;
  endfunction

  function automatic logic is_stat(input logic [6:0] a);
    return (a == STAT_ERR_ADDR) || (a == STAT_FRM_ADDR);
  endfunction

endpackage

// File: rtl/block_spi_reg_decoder_reg_bank.sv
// NUM_REGS x 8 register storage: synchronous write, asynchronous read,
// whole bank exposed flat (reg k at [8k+7:8k]).
module block_reg_bank
  import block_spi_reg_decoder_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [6:0]            waddr,
  input  logic [7:0]            wdata,
  input  logic [6:0]            raddr,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  logic [NUM_REGS-1:0][7:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= {NUM_REGS{REG_RESET}};
    end else if (we) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (waddr == 7'(k)) mem[k] <= wdata;
    end
  end

  // Addresses beyond the bank read as zero.
  always_comb begin
    rdata = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (raddr == 7'(k)) rdata = mem[k];
  end

  assign regs_flat = mem;

endmodule

// File: rtl/block_spi_reg_decoder.sv
// Parses CS-delimited SPI byte frames into register bank writes/reads.
// Optional SPI_DECODER_STATS_EN adds frame/error counters readable at 126/127.
module block_spi_reg_decoder
  import block_spi_reg_decoder_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
`ifdef SPI_DECODER_STATS_EN
  output logic [15:0]           frame_count,
  output logic [7:0]            err_count,
`endif
  output logic                  frame_err
);

  state_t     state;
  logic [6:0] addr, nxt_addr, rd_addr;
  logic [7:0] bank_rd, rd_val;
  logic       rd_err, wr_ok, wr_err, bank_we;

  always_comb begin
    nxt_addr = addr_inc(addr);
    // Header read uses the address inside the byte itself; later reads pre-increment.
    rd_addr  = (state == S_HEADER) ? rx_data[6:0] : nxt_addr;
    rd_val   = 8'h00;
    rd_err   = 1'b0;
    if (in_range(rd_addr, NUM_REGS)) rd_val = bank_rd;
    else                             rd_err = 1'b1;
    wr_ok    = in_range(addr, NUM_REGS);
    wr_err   = !wr_ok;
`ifdef SPI_DECODER_STATS_EN
    if (rd_addr == STAT_ERR_ADDR) begin rd_val = err_count;         rd_err = 1'b0; end
    if (rd_addr == STAT_FRM_ADDR) begin rd_val = frame_count[7:0];  rd_err = 1'b0; end
    if (is_stat(addr)) begin wr_ok = 1'b0; wr_err = 1'b0; end
`endif
    bank_we  = (state == S_WRITE) && rx_valid && !cs_n && wr_ok;
  end

  block_reg_bank #(.NUM_REGS(NUM_REGS), .REG_RESET(REG_RESET)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bank_we),
    .waddr     (addr),
    .wdata     (rx_data),
    .raddr     (rd_addr),
    .rdata     (bank_rd),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_SYNC;
      addr      <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
`ifdef SPI_DECODER_STATS_EN
      frame_count <= '0;
      err_count   <= '0;
`endif
    end else begin
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      if (state == S_SYNC) begin
        if (cs_n) state <= S_IDLE;
      end else if (cs_n) begin
        // Frame end wins over any byte landing in the same clock.
        state <= S_IDLE;
`ifdef SPI_DECODER_STATS_EN
        if (state == S_WRITE || state == S_READ) begin
          frame_count <= frame_count + 16'd1;
          if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
`endif
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_HEADER;
            frame_err <= 1'b0;
          end
          S_HEADER: if (rx_valid) begin
            addr <= rx_data[6:0];
            if (rx_data[RW_BIT]) begin
              state <= S_WRITE;
            end else begin
              state    <= S_READ;
              tx_data  <= rd_val;
              tx_valid <= 1'b1;
              if (rd_err) frame_err <= 1'b1;
            end
          end
          S_WRITE: if (rx_valid) begin
            addr <= nxt_addr;
            if (wr_ok) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= rx_data;
            end else if (wr_err) begin
              frame_err <= 1'b1;
            end
          end
          S_READ: if (rx_valid) begin
            addr     <= nxt_addr;
            tx_data  <= rd_val;
            tx_valid <= 1'b1;
            if (rd_err) frame_err <= 1'b1;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_spi_reg_decoder.sv
// Randomized frame-level bench for block_spi_reg_decoder against a register-array model.
module tb_block_spi_reg_decoder;

  localparam int NR = 16;

  logic          clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [7:0]    tx_data, wr_data;
  logic          tx_valid, wr_strobe, frame_err;
  logic [6:0]    wr_addr;
  logic [NR*8-1:0] regs_flat;

  block_spi_reg_decoder #(.NUM_REGS(NR), .REG_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [7:0]  mref [NR];
  logic [14:0] wq [$];
  logic [7:0]  tq [$];
  logic [7:0]  dq [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe outputs just after each edge; tx_valid must coincide with the byte just taken.
  always @(posedge clk) begin
    #2;
    if (wr_strobe) wq.push_back({wr_addr, wr_data});
    if (tx_valid) begin
      tq.push_back(tx_data);
      chk("tx_latency", 128'(rx_valid), 128'd1);
    end
  end

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = mref[k];
    return f;
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    return (a < NR) ? mref[a] : 8'h00;
  endfunction

  function automatic int sat_inc(input int a);
    return (a >= 127) ? 127 : a + 1;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk); cs_n = 1'b0; wq.delete(); tq.delete();
    @(negedge clk);
    chk("err_clear_on_start", 128'(frame_err), 128'd0);
  endtask

  task automatic end_frame();
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk);
  endtask

  // Header plus the bytes in dq; the model predicts writes, read-backs and frame_err.
  task automatic do_frame(input bit wr, input int start);
    logic [14:0] ewq [$];
    logic [7:0]  etq [$];
    int a = start;
    bit err = 0;
    start_frame();
    send({wr, 7'(start)});
    if (!wr) begin
      if (a >= NR) err = 1;
      etq.push_back(model_rd(a));
    end
    foreach (dq[i]) begin
      send(dq[i]);
      if (wr) begin
        if (a < NR) begin mref[a] = dq[i]; ewq.push_back({7'(a), dq[i]}); end
        else err = 1;
        a = sat_inc(a);
      end else begin
        a = sat_inc(a);
        if (a >= NR) err = 1;
        etq.push_back(model_rd(a));
      end
    end
    @(negedge clk);
    chk("frame_err", 128'(frame_err), 128'(err));
    chk("wr_count", 128'(wq.size()), 128'(ewq.size()));
    chk("tx_count", 128'(tq.size()), 128'(etq.size()));
    for (int i = 0; i < ewq.size() && i < wq.size(); i++) chk("wr_addr_data", 128'(wq[i]), 128'(ewq[i]));
    for (int i = 0; i < etq.size() && i < tq.size(); i++) chk("tx_data", 128'(tq[i]), 128'(etq[i]));
    end_frame();
    chk("regs_flat", regs_flat, model_flat());
  endtask

  initial begin
    int sel, st, n;
    for (int k = 0; k < NR; k++) mref[k] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx_data", 128'(tx_data), 0);
    chk("rst_tx_valid", 128'(tx_valid), 0);
    chk("rst_wr_strobe", 128'(wr_strobe), 0);
    chk("rst_wr_addr", 128'(wr_addr), 0);
    chk("rst_wr_data", 128'(wr_data), 0);
    chk("rst_frame_err", 128'(frame_err), 0);
    chk("rst_regs", regs_flat, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    dq.delete(); dq.push_back(8'hAA); dq.push_back(8'hBB);
    do_frame(1, 2);
    dq.delete(); dq.push_back(8'h00); dq.push_back(8'h00);
    do_frame(0, 2);
    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
    do_frame(1, 15);
    dq.delete();
    do_frame(0, 3);

    // cs_n rising together with a data byte: byte must be dropped
    start_frame();
    send(8'h85);
    @(negedge clk); rx_data = 8'h77; rx_valid = 1'b1; cs_n = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("discard_wr_count", 128'(wq.size()), 0);
    chk("discard_regs", regs_flat, model_flat());
    dq.delete(); dq.push_back(8'h00);
    do_frame(0, 5);

    // reset in the middle of a write frame, cs_n held low
    start_frame();
    send(8'h80);
    send(8'h12);
    mref[0] = 8'h12;
    chk("pre_rst_wr_count", 128'(wq.size()), 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < NR; k++) mref[k] = 8'h00;
    wq.delete(); tq.delete();
    send(8'h34);
    send(8'h56);
    chk("post_rst_wr_count", 128'(wq.size()), 0);
    chk("post_rst_tx_count", 128'(tq.size()), 0);
    chk("post_rst_regs", regs_flat, 0);
    end_frame();
    dq.delete(); dq.push_back(8'h9A);
    do_frame(1, 1);

    // empty frame
    start_frame();
    repeat (3) @(negedge clk);
    end_frame();
    chk("empty_wr_count", 128'(wq.size()), 0);
    chk("empty_tx_count", 128'(tq.size()), 0);
    chk("empty_regs", regs_flat, model_flat());

    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: st = $urandom_range(0, NR - 1);
        1: st = $urandom_range(NR - 4, NR + 3);
        2: st = $urandom_range(124, 127);
        default: st = $urandom_range(0, 127);
      endcase
      n = $urandom_range(0, 5);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      do_frame(1'($urandom_range(0, 1)), st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
